cart_load_ctrl: RTL and testbench
=================================

Name: cart_load_ctrl

Overview:
- Sequences cartridge loading into the 64 KB ROM dual-port RAM and owns that RAM's read port.
- During an HPS download it forwards write bytes to RAM and counts the image size.
- After the download it scans the image to choose a bank-switch scheme, then hands the read port back to the CPU core and releases the core's hold.
- Replaces the ad-hoc extension decoder and init-reset logic at the emu top level.

Parameters:
- ADDR_W, 16, ROM RAM address width; the maximum image is 2^ADDR_W bytes.
- E0_MIN_HITS, 2, number of E0 hotspot-access signatures needed to select scheme 4.
- F3_MIN_HITS, 2, number of "STA $3F" signatures needed to select scheme 5.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_wr  in  1  download byte strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download byte.
- ioctl_file_ext  in  32  file extension, ASCII, extension in [23:0].
- sc_req  in  1  SuperChip menu option, sampled at download start.
- core_addr  in  ADDR_W  CPU core ROM read address.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_W  RAM write address.
- mem_wdata  out  8  RAM write data.
- mem_raddr  out  ADDR_W  RAM read-port address (muxed between scanner and core).
- mem_q  in  8  RAM read data; valid 1 cycle after mem_raddr.
- rom_size  out  ADDR_W+1  byte count of the loaded image.
- force_bs  out  4  bank-switch scheme to the core.
- sc  out  1  latched SuperChip enable.
- core_hold  out  1  holds the core in reset; high while not READY.
- busy  out  1  high in LOAD or SCAN.

Behaviour:
- Reset: state IDLE; rom_size=0, force_bs=0, sc=0, mem_we=0, busy=0, core_hold=1.
- Before any completed load, core_hold stays 1 in IDLE.
- States: IDLE, LOAD, SCAN, READY.
- IDLE/READY -> LOAD on a rising edge of ioctl_download.
  - On entry: latch sc<=sc_req, rom_size<=0, clear all hit counters, set ext_bs from the extension.
  - Extension map: .F8=1, .F6=2, .FE=3, .E0=4, .3F=5, .F4=6, .P2=7, .FA=8; anything else is 0, meaning "auto".
- LOAD: mem_we=ioctl_wr, mem_waddr=ioctl_addr[ADDR_W-1:0], mem_wdata=ioctl_dout, with zero added latency (combinational pass-through).
  - On each ioctl_wr: rom_size <= max(rom_size, ioctl_addr+1), saturating at 2^ADDR_W.
  - Writes with ioctl_addr >= 2^ADDR_W are dropped (mem_we=0).
- LOAD -> SCAN when ioctl_download falls.
  - If rom_size==0 or ext_bs!=0, skip the scan and go straight to the resolve step.
- SCAN: mem_raddr steps 0..rom_size-1, one address per cycle.
  - The byte returned for address n is consumed on the following cycle.
  - A 3-byte shift window (b2,b1,b0) is checked each consumed byte.
  - E0 hit: b2 in {8D,AD}, b1 in E0..E7, b0 in {1F,FF}.
  - 3F hit: b1=85, b0=3F.
  - Hit counters are 4 bits and saturate at 15.
  - SCAN lasts exactly rom_size+1 cycles (address phase plus one flush cycle), then resolves.
- Resolve (1 cycle), first match wins:
  - ext_bs!=0 -> ext_bs
  - 3F hits >= F3_MIN_HITS and rom_size>=8K -> 5
  - E0 hits >= E0_MIN_HITS and rom_size==8K -> 4
  - rom_size<=4K -> 0; <=8K -> 1; <=16K -> 2; <=32K -> 6; otherwise 0
- Resolve then moves to READY.
- force_bs updates only in the resolve cycle, so it is stable throughout LOAD and SCAN.
- READY: core_hold=0, busy=0, mem_raddr=core_addr.
- Outside READY, mem_raddr is scanner-driven in SCAN and 0 otherwise.
- A new rising edge of ioctl_download in any state (including mid-SCAN) aborts the current state and restarts LOAD.
- reset_n low mid-operation returns to the reset values in the next cycle; RAM contents are untouched.
- Download fall and rise in the same cycle cannot occur (edge detected on a registered copy).

Optional Feature:
- Macro: CART_AUTODETECT_EN.
- Defined: full SCAN state and signature counters as described.
- Undefined: SCAN state and counters are not built.
  - LOAD -> resolve directly.
  - Resolve uses only ext_bs and the size rules.
  - busy drops 1 cycle after the download falls.

Test Plan:
- Reset with reset_n=0 for 3 cycles -> force_bs=0, sc=0, rom_size=0, core_hold=1, busy=0; remains so with no download.
- Load 4096 bytes with ext ".BIN", sc_req=1 -> rom_size=4096, sc=1, SCAN lasts 4097 cycles, force_bs=0, core_hold falls after resolve, mem_raddr tracks core_addr.
- Load 8192 bytes with ext ".F6" -> scan skipped, force_bs=2, busy high for exactly 2 cycles after the download falls.
- Load 8192 bytes containing "8D E0 1F" at 0x0100 and "AD E7 FF" at 0x1200, ext ".BIN" -> force_bs=4; the same image with one signature removed -> force_bs=1.
- Load 16384 bytes containing "85 3F" three times -> force_bs=5; a 32768-byte image with no signatures -> force_bs=6.
- During SCAN of a 32K image at address 0x2000, raise ioctl_download -> state LOAD, counters cleared, rom_size=0; a new 2048-byte load gives force_bs=0. Separately, reset_n=0 mid-LOAD -> IDLE with core_hold=1 and mem_we=0 the next cycle.

Source files
------------

// File: rtl/cart_load_ctrl.sv
// Cartridge download sequencer: forwards HPS bytes to ROM RAM, sizes the image, picks a bank-switch scheme.
// Signature autodetect (SCAN state and hit counters) is built only when CART_AUTODETECT_EN is defined.
module cart_load_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int E0_MIN_HITS = 2,
  parameter int F3_MIN_HITS = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [31:0]       ioctl_file_ext,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_q,
  output logic [ADDR_W:0]   rom_size,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic              core_hold,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, RESOLVE, READY} state_t;

  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] SZ_4K    = (ADDR_W+1)'(4096);
  localparam logic [ADDR_W:0] SZ_8K    = (ADDR_W+1)'(8192);
  localparam logic [ADDR_W:0] SZ_16K   = (ADDR_W+1)'(16384);
  localparam logic [ADDR_W:0] SZ_32K   = (ADDR_W+1)'(32768);
  localparam logic [3:0]      E0_MIN   = 4'(E0_MIN_HITS);
  localparam logic [3:0]      F3_MIN   = 4'(F3_MIN_HITS);

  function automatic logic [3:0] ext_to_bs(input logic [23:0] ext);
    case (ext)
      ".F8":   return 4'd1;
      ".F6":   return 4'd2;
      ".FE":   return 4'd3;
      ".E0":   return 4'd4;
      ".3F":   return 4'd5;
      ".F4":   return 4'd6;
      ".P2":   return 4'd7;
      ".FA":   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] resolve_bs(input logic [3:0] ext_bs, input logic [3:0] e0_hits,
                                            input logic [3:0] f3_hits, input logic [ADDR_W:0] size);
    if (ext_bs != 4'd0) return ext_bs;
    if (f3_hits >= F3_MIN && size >= SZ_8K) return 4'd5;
    if (e0_hits >= E0_MIN && size == SZ_8K) return 4'd4;
    if (size <= SZ_4K) return 4'd0;
    if (size <= SZ_8K) return 4'd1;
    if (size <= SZ_16K) return 4'd2;
    if (size <= SZ_32K) return 4'd6;
    return 4'd0;
  endfunction

  state_t            state_q, state_d;
  logic              dl_q;
  logic [ADDR_W:0]   rom_size_q, rom_size_d;
  logic [3:0]        force_bs_q, force_bs_d;
  logic              sc_q, sc_d;
  logic [3:0]        ext_bs_q, ext_bs_d;
  logic              dl_rise, dl_fall, in_range;
  logic [ADDR_W:0]   wr_end;
  logic              unused_bits;

`ifdef CART_AUTODETECT_EN
  function automatic logic [3:0] sat_inc4(input logic [3:0] cnt, input logic hit);
    return (hit && cnt != 4'hF) ? cnt + 4'd1 : cnt;
  endfunction

  function automatic logic is_e0(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    return (b2 == 8'h8D || b2 == 8'hAD) && (b1[7:3] == 5'b11100) && (b0 == 8'h1F || b0 == 8'hFF);
  endfunction

  logic [ADDR_W:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]      win0_q, win0_d, win1_q, win1_d;
  logic [3:0]      hits_e0_q, hits_e0_d, hits_3f_q, hits_3f_d;

  assign unused_bits = ^ioctl_file_ext[31:24];
`else
  assign unused_bits = ^{ioctl_file_ext[31:24], mem_q};
`endif

  assign in_range  = (ioctl_addr[24:ADDR_W] == '0);
  assign wr_end    = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + ONE) : MAX_SIZE;
  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;

  always_comb begin
    state_d    = state_q;
    rom_size_d = rom_size_q;
    force_bs_d = force_bs_q;
    sc_d       = sc_q;
    ext_bs_d   = ext_bs_q;
    mem_we     = 1'b0;
    mem_waddr  = ioctl_addr[ADDR_W-1:0];
    mem_wdata  = ioctl_dout;
    mem_raddr  = '0;
`ifdef CART_AUTODETECT_EN
    scan_cnt_d = scan_cnt_q;
    win0_d     = win0_q;
    win1_d     = win1_q;
    hits_e0_d  = hits_e0_q;
    hits_3f_d  = hits_3f_q;
`endif
    case (state_q)
      LOAD: begin
        mem_we = ioctl_wr & in_range;
        if (ioctl_wr && wr_end > rom_size_q) rom_size_d = wr_end;
        if (dl_fall) begin
`ifdef CART_AUTODETECT_EN
          state_d    = (rom_size_q == '0 || ext_bs_q != 4'd0) ? RESOLVE : SCAN;
          scan_cnt_d = '0;
          win0_d     = 8'h00;
          win1_d     = 8'h00;
`else
          force_bs_d = resolve_bs(ext_bs_q, 4'd0, 4'd0, rom_size_q);
          state_d    = READY;
`endif
        end
      end
`ifdef CART_AUTODETECT_EN
      // Address n goes out on scan count n; its byte comes back and is consumed on count n+1.
      SCAN: begin
        mem_raddr  = scan_cnt_q[ADDR_W-1:0];
        scan_cnt_d = scan_cnt_q + ONE;
        if (scan_cnt_q != '0) begin
          win1_d    = win0_q;
          win0_d    = mem_q;
          hits_e0_d = sat_inc4(hits_e0_q, is_e0(win1_q, win0_q, mem_q));
          hits_3f_d = sat_inc4(hits_3f_q, win0_q == 8'h85 && mem_q == 8'h3F);
        end
        if (scan_cnt_q == rom_size_q) state_d = RESOLVE;
      end
      RESOLVE: begin
        force_bs_d = resolve_bs(ext_bs_q, hits_e0_q, hits_3f_q, rom_size_q);
        state_d    = READY;
      end
`endif
      READY:   mem_raddr = core_addr;
      default: ;
    endcase
    // A new download start overrides whatever the current state was doing.
    if (dl_rise) begin
      state_d    = LOAD;
      sc_d       = sc_req;
      rom_size_d = '0;
      force_bs_d = force_bs_q;
      ext_bs_d   = ext_to_bs(ioctl_file_ext[23:0]);
`ifdef CART_AUTODETECT_EN
      hits_e0_d  = 4'd0;
      hits_3f_d  = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      rom_size_q <= '0;
      force_bs_q <= 4'd0;
      sc_q       <= 1'b0;
      ext_bs_q   <= 4'd0;
`ifdef CART_AUTODETECT_EN
      scan_cnt_q <= '0;
      hits_e0_q  <= 4'd0;
      hits_3f_q  <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      rom_size_q <= rom_size_d;
      force_bs_q <= force_bs_d;
      sc_q       <= sc_d;
      ext_bs_q   <= ext_bs_d;
`ifdef CART_AUTODETECT_EN
      scan_cnt_q <= scan_cnt_d;
      hits_e0_q  <= hits_e0_d;
      hits_3f_q  <= hits_3f_d;
`endif
    end
  end

`ifdef CART_AUTODETECT_EN
  always_ff @(posedge clk_sys) begin
    win0_q <= win0_d;
    win1_q <= win1_d;
  end
`endif

  assign rom_size  = rom_size_q;
  assign force_bs  = force_bs_q;
  assign sc        = sc_q;
  assign core_hold = (state_q != READY);
  assign busy      = (state_q == LOAD) || (state_q == SCAN) || (state_q == RESOLVE);

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Testbench for cart_load_ctrl: HPS-style downloads with random data, a ROM RAM model, and a
// behavioural model of image size, scan length and bank-switch selection.
`timescale 1ns/1ps
module tb_cart_load_ctrl;
`ifdef CART_AUTODETECT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int ADDR_W = 16;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download, ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [31:0]       ioctl_file_ext;
  logic              sc_req;
  logic [ADDR_W-1:0] core_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [7:0]        mem_wdata, mem_q;
  logic [ADDR_W:0]   rom_size;
  logic [3:0]        force_bs;
  logic              sc, core_hold, busy;

  logic [7:0] ram [0:MEM_SZ-1];
  logic [7:0] img [0:MEM_SZ-1];
  logic       ram_clr;

  int n_checks = 0;
  int n_errors = 0;
  int exp_size, exp_ext, prev_bs, wr_bad;
  bit exp_sc;

  logic [23:0] ext_tab  [9] = '{".F8", ".F6", ".FE", ".E0", ".3F", ".F4", ".P2", ".FA", ".XY"};
  int          code_tab [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

  always #5 clk_sys = ~clk_sys;

  cart_load_ctrl #(.ADDR_W(ADDR_W), .E0_MIN_HITS(2), .F3_MIN_HITS(2)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_file_ext(ioctl_file_ext),
    .sc_req(sc_req), .core_addr(core_addr), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_q(mem_q), .rom_size(rom_size),
    .force_bs(force_bs), .sc(sc), .core_hold(core_hold), .busy(busy)
  );

  always @(posedge clk_sys) begin
    if (ram_clr) begin
      for (int i = 0; i < MEM_SZ; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_q <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_bs(input int extc, input int size);
    int e0 = 0;
    int f3 = 0;
    if (extc != 0) return extc;
    if (AUTO) begin
      for (int i = 0; i < size; i++) begin
        if (i >= 2 && (img[i-2] == 8'h8D || img[i-2] == 8'hAD) && img[i-1] >= 8'hE0 &&
            img[i-1] <= 8'hE7 && (img[i] == 8'h1F || img[i] == 8'hFF) && e0 < 15) e0++;
        if (i >= 1 && img[i-1] == 8'h85 && img[i] == 8'h3F && f3 < 15) f3++;
      end
    end
    if (f3 >= 2 && size >= 8192) return 5;
    if (e0 >= 2 && size == 8192) return 4;
    if (size <= 4096) return 0;
    if (size <= 8192) return 1;
    if (size <= 16384) return 2;
    if (size <= 32768) return 6;
    return 0;
  endfunction

  task automatic dl_begin(input logic [31:0] ext, input int code, input bit scr);
    ioctl_file_ext = ext;
    sc_req         = scr;
    ioctl_download = 1'b1;
    exp_ext = code; exp_sc = scr; exp_size = 0; wr_bad = 0;
    @(negedge clk_sys);
    sc_req = ~scr;
  endtask

  task automatic dl_wr(input int addr, input logic [7:0] data);
    bit inr;
    inr = (addr < MEM_SZ);
    ioctl_wr = 1'b1; ioctl_addr = 25'(addr); ioctl_dout = data;
    #1;
    if (mem_we !== inr) wr_bad++;
    else if (inr && (mem_waddr !== 16'(addr) || mem_wdata !== data)) wr_bad++;
    if (inr) img[addr] = data;
    if (addr + 1 > MEM_SZ) exp_size = MEM_SZ;
    else if (addr + 1 > exp_size) exp_size = addr + 1;
    @(negedge clk_sys);
  endtask

  task automatic dl_end(input string tag);
    int n, exp_len, bs, idx_bad;
    bit skip;
    ioctl_wr = 1'b0;
    #1;
    chk({tag, "_size"}, rom_size, exp_size);
    chk({tag, "_sc"}, sc, exp_sc);
    chk({tag, "_bs_stable"}, force_bs, prev_bs);
    chk({tag, "_wr_pass"}, wr_bad, 0);
    skip    = (exp_ext != 0 || exp_size == 0);
    exp_len = !AUTO ? 1 : (skip ? 2 : exp_size + 3);
    ioctl_download = 1'b0;
    #1;
    n = 0; idx_bad = 0;
    while (busy === 1'b1 && n < 70000) begin
      if (n >= 1 && n <= exp_size && mem_raddr !== 16'(n - 1)) idx_bad++;
      n++;
      @(negedge clk_sys);
      #1;
    end
    chk({tag, "_busy_len"}, n, exp_len);
    if (!skip) chk({tag, "_scan_addr"}, idx_bad, 0);
    bs = model_bs(exp_ext, exp_size);
    chk({tag, "_force_bs"}, force_bs, bs);
    chk({tag, "_hold"}, core_hold, 0);
    core_addr = 16'($urandom);
    #1;
    chk({tag, "_raddr_core"}, mem_raddr, core_addr);
    prev_bs = bs;
    @(negedge clk_sys);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    ioctl_file_ext = '0; sc_req = 1'b0; core_addr = '0; ram_clr = 1'b1; prev_bs = 0;
    for (int i = 0; i < MEM_SZ; i++) img[i] = 8'h00;
    repeat (3) @(negedge clk_sys);
    ram_clr = 1'b0;
    chk("rst_bs", force_bs, 0);
    chk("rst_sc", sc, 0);
    chk("rst_size", rom_size, 0);
    chk("rst_hold", core_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("idle_hold", core_hold, 1);
    chk("idle_busy", busy, 0);
    chk("idle_bs", force_bs, 0);
    chk("idle_raddr", mem_raddr, 0);

    dl_begin(32'(".BIN"), 0, 1'b1);
    for (int a = 0; a < 4096; a++) dl_wr(a, 8'($urandom) & 8'h7F);
    dl_end("t4k");
    for (int k = 0; k < 3; k++) begin
      core_addr = 16'($urandom);
      #1;
      chk("ready_raddr", mem_raddr, core_addr);
      @(negedge clk_sys);
    end

    dl_begin(32'(".F6"), 2, 1'b0);
    dl_wr(16'h1FFF, 8'h11);
    dl_end("tf6");

    dl_begin(32'(".BIN"), 0, 1'b0);
    dl_wr(16'h0100, 8'h8D); dl_wr(16'h0101, 8'hE0); dl_wr(16'h0102, 8'h1F);
    dl_wr(16'h1200, 8'hAD); dl_wr(16'h1201, 8'hE7); dl_wr(16'h1202, 8'hFF);
    dl_wr(16'h1FFF, 8'h00);
    dl_end("te0_two");

    dl_begin(32'(".BIN"), 0, 1'b0);
    dl_wr(16'h1201, 8'h00); dl_wr(16'h1FFF, 8'h00);
    dl_end("te0_one");

    dl_begin(32'(".BIN"), 0, 1'b1);
    dl_wr(16'h2100, 8'h85); dl_wr(16'h2101, 8'h3F);
    dl_wr(16'h2800, 8'h85); dl_wr(16'h2801, 8'h3F);
    dl_wr(16'h3000, 8'h85); dl_wr(16'h3001, 8'h3F);
    dl_wr(16'h3FFF, 8'h00);
    dl_end("t3f");

    dl_begin(32'(".BIN"), 0, 1'b0);
    dl_wr(16'h2101, 8'h00); dl_wr(16'h2801, 8'h00); dl_wr(16'h3001, 8'h00);
    dl_wr(16'h7FFF, 8'h00);
    dl_end("t32k");

    dl_begin(32'(".BIN"), 0, 1'b1);
    dl_wr(16'h7FFF, 8'h22);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && mem_raddr !== 16'h2000 && n < 20000) begin
      @(negedge clk_sys);
      #1;
      n++;
    end
    ioctl_download = 1'b1;
    sc_req = 1'b0;
    @(negedge clk_sys);
    #1;
    chk("abort_busy", busy, 1);
    chk("abort_size", rom_size, 0);
    chk("abort_hold", core_hold, 1);
    chk("abort_raddr", mem_raddr, 0);
    chk("abort_sc", sc, 0);
    chk("abort_bs_kept", force_bs, prev_bs);
    exp_size = 0; exp_sc = 1'b0; exp_ext = 0; wr_bad = 0;
    @(negedge clk_sys);
    dl_wr(16'h07FF, 8'h33);
    dl_end("t2k");

    for (int r = 0; r < 4; r++) begin
      int k, sz;
      k  = $urandom_range(0, 8);
      sz = $urandom_range(1, 600);
      dl_begin({8'h00, ext_tab[k]}, code_tab[k], 1'($urandom));
      for (int a = 0; a < sz; a++) dl_wr(a, 8'($urandom));
      dl_end("trnd");
    end

    dl_begin(32'(".F8"), 1, 1'b1);
    dl_wr(0, 8'h01); dl_wr(1, 8'h02);
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h55;
    #1;
    chk("oob_we", mem_we, 0);
    @(negedge clk_sys);
    #1;
    chk("oob_size_sat", rom_size, MEM_SZ);
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_addr = 25'd5;
    @(negedge clk_sys);
    #1;
    chk("mid_rst_hold", core_hold, 1);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_size", rom_size, 0);
    chk("mid_rst_bs", force_bs, 0);
    chk("mid_rst_sc", sc, 0);
    ioctl_wr = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
